// File: rtl/ex_mem_elastic_if.sv
// EX/MEM handshake bundle: EX-side entry fields, MEM-side outputs, flush and
// the backpressure counter. slave = pipeline register, master = surroundings.
interface ex_mem_elastic_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REGADDR_W = 5,
  parameter int unsigned MEMADDR_W = 32,
  parameter int unsigned MEMRW_W   = 2,
  parameter int unsigned CNT_W     = 16
);
  logic                 flush;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [MEMRW_W-1:0]   ex_memrw;
  logic [MEMADDR_W-1:0] ex_memaddr;
  logic [DATA_W-1:0]    ex_wdata;
  logic [REGADDR_W-1:0] ex_waddr;
  logic                 ex_we;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [MEMRW_W-1:0]   mem_memrw;
  logic [MEMADDR_W-1:0] mem_memaddr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [REGADDR_W-1:0] mem_waddr;
  logic                 mem_we;
  logic [CNT_W-1:0]     bp_count;

  modport slave (
    input  flush, ex_valid, ex_memrw, ex_memaddr, ex_wdata, ex_waddr, ex_we, mem_ready,
    output ex_ready, mem_valid, mem_memrw, mem_memaddr, mem_wdata, mem_waddr, mem_we, bp_count
  );

  modport master (
    output flush, ex_valid, ex_memrw, ex_memaddr, ex_wdata, ex_waddr, ex_we, mem_ready,
    input  ex_ready, mem_valid, mem_memrw, mem_memaddr, mem_wdata, mem_waddr, mem_we, bp_count
  );
endinterface

// File: rtl/ex_mem_elastic.sv
// Elastic EX/MEM pipeline register: valid/ready handshake over a two-entry
// skid buffer (main M drives MEM, skid S catches one overflow entry).
module ex_mem_elastic #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          REGADDR_W  = 5,
  parameter int unsigned          MEMADDR_W  = 32,
  parameter int unsigned          MEMRW_W    = 2,
  parameter logic [MEMRW_W-1:0]   MEMRW_IDLE = '0,
  parameter int unsigned          CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  ex_mem_elastic_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_e;

  typedef struct packed {
    logic [MEMRW_W-1:0]   memrw;
    logic [MEMADDR_W-1:0] memaddr;
    logic [DATA_W-1:0]    wdata;
    logic [REGADDR_W-1:0] waddr;
    logic                 we;
  } entry_t;

  state_e           state_q;
  logic             ready_q;
  entry_t           m_q;
  entry_t           s_q;
  logic [CNT_W-1:0] bp_q;

  entry_t ex_entry;
  logic   m_valid;
  logic   in_fire;
  logic   out_fire;

  assign ex_entry = {bus.ex_memrw, bus.ex_memaddr, bus.ex_wdata, bus.ex_waddr, bus.ex_we};
  assign m_valid  = (state_q == HALF) || (state_q == FULL);
  assign in_fire  = bus.ex_valid && ready_q;
  assign out_fire = m_valid && bus.mem_ready;

  // ready_q is kept equal to !S.valid by updating it alongside every state move
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b1;
      m_q         <= '0;
      m_q.memrw   <= MEMRW_IDLE;
      s_q         <= '0;
      s_q.memrw   <= MEMRW_IDLE;
      bp_q        <= '0;
    end else begin
      if (m_valid && !bus.mem_ready && (bp_q != '1)) begin
        bp_q <= bp_q + 1'b1;
      end

      if (bus.flush) begin
        state_q <= EMPTY;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (in_fire) begin
              m_q     <= ex_entry;
              state_q <= HALF;
            end
          end
          HALF: begin
            if (in_fire && out_fire) begin
              m_q <= ex_entry;
            end else if (in_fire) begin
              s_q     <= ex_entry;
              state_q <= FULL;
              ready_q <= 1'b0;
            end else if (out_fire) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              m_q     <= s_q;
              state_q <= HALF;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Side-effect fields are squashed for bubbles; data fields keep their held value
  assign bus.ex_ready    = ready_q;
  assign bus.mem_valid   = m_valid;
  assign bus.mem_memrw   = m_valid ? m_q.memrw : MEMRW_IDLE;
  assign bus.mem_we      = m_valid && m_q.we;
  assign bus.mem_memaddr = m_q.memaddr;
  assign bus.mem_wdata   = m_q.wdata;
  assign bus.mem_waddr   = m_q.waddr;
  assign bus.bp_count    = bp_q;

endmodule
